brm_rate_mult: RTL

//  Parametrised multi-channel binary rate multiplier; successor to the fixed 16-bit counter/compare benchmark.
//  One shared W-bit up-counter, advanced by EN, drives NCH independent channels.

---
 rtl/brm_rate_mult.sv | 95 +++++++++
 1 files changed

// File: rtl/brm_rate_mult.sv
// Multi-channel binary rate multiplier: one shared W-bit counter drives NCH channels, and each
// channel emits RATE_k pulses per 2^W enabled cycles from a double-buffered rate word.
module brm_rate_mult #(
  parameter int unsigned W   = 4,
  parameter int unsigned NCH = 2,
  parameter int unsigned SW  = 1
) (
  input  logic           CK,
  input  logic           RN,
  input  logic           EN,
  input  logic           CLR,
  input  logic           WE,
  input  logic [SW-1:0]  WSEL,
  input  logic [W-1:0]   WDATA,
  output logic [NCH-1:0] PEND,
  output logic [NCH-1:0] Z,
  output logic           TC,
  output logic [W-1:0]   CNT
);

  localparam logic [W-1:0] CntMax = {W{1'b1}};

  logic [W-1:0]   cnt_q, cnt_d;
  logic [W-1:0]   rate_q   [NCH];
  logic [W-1:0]   rate_d   [NCH];
  logic [W-1:0]   shadow_q [NCH];
  logic [W-1:0]   shadow_d [NCH];
  logic [NCH-1:0] pend_q, pend_d;
  logic [NCH-1:0] z_q, z_d;
  logic           tc_q, tc_d;
  logic           step, apply;
  logic [W-1:0]   first_zero;

  assign step  = EN && !CLR;
  assign apply = CLR || (step && (cnt_q == CntMax));
  // One-hot at the lowest zero bit of the counter, i.e. bit j = trailing-ones count.
  assign first_zero = ~cnt_q & (cnt_q + 1'b1);

  always_comb begin
    cnt_d  = cnt_q;
    tc_d   = 1'b0;
    z_d    = '0;
    pend_d = pend_q;
    if (CLR) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = cnt_q + 1'b1;
      tc_d  = (cnt_q == CntMax);
    end
    for (int k = 0; k < NCH; k++) begin
      rate_d[k]   = rate_q[k];
      shadow_d[k] = shadow_q[k];
      if (step) begin
        for (int i = 0; i < W; i++) begin
          z_d[k] = z_d[k] | (first_zero[i] & rate_q[k][W-1-i]);
        end
      end
      // Apply reads the pre-write shadow; a same-cycle write stays pending.
      if (apply && pend_q[k]) begin
        rate_d[k] = shadow_q[k];
        pend_d[k] = 1'b0;
      end
      if (WE && (WSEL == SW'(k))) begin
        shadow_d[k] = WDATA;
        pend_d[k]   = 1'b1;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (!RN) begin
      cnt_q  <= '0;
      pend_q <= '0;
      z_q    <= '0;
      tc_q   <= 1'b0;
      for (int k = 0; k < NCH; k++) begin
        rate_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
    end else begin
      cnt_q    <= cnt_d;
      pend_q   <= pend_d;
      z_q      <= z_d;
      tc_q     <= tc_d;
      rate_q   <= rate_d;
      shadow_q <= shadow_d;
    end
  end

  assign CNT  = cnt_q;
  assign PEND = pend_q;
  assign Z    = z_q;
  assign TC   = tc_q;

endmodule
